// File: rtl/alu_iter.sv
// alu_iter: valid/ready ALU with single-cycle base ops and a bit-serial multiply/divide unit.
// The multiply/divide unit is built only when ALU_ITER_MULDIV_EN is defined; otherwise ops 1010-1111 return 0.
module alu_iter #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               imm_en,
  input  logic [XLEN-1:0]    a,
  input  logic [XLEN-1:0]    b,
  input  logic [XLEN-1:0]    imm,
  input  logic [3:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_data,
  output logic               busy,
  output logic [1:0]         dbg_state
);
  // Handshake: a transfer occurs on a rising edge where valid and ready are both high.
  // in_ready is high only in IDLE; out_valid is high only in DONE and holds with out_data until out_ready.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] op2;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] iter_res;
  logic            accept;
  logic            start_iter;
  logic            iter_last;

  assign op2    = imm_en ? imm : b;
  assign accept = in_valid && in_ready;

  always_comb begin
    alu_res = '0;
    case (op)
      4'b0000: alu_res = a + op2;
      4'b0001: alu_res = a - op2;
      4'b0010: alu_res = a << shamt;
      4'b0011: alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(op2))};
      4'b0100: alu_res = {{(XLEN-1){1'b0}}, (a < op2)};
      4'b0101: alu_res = a ^ op2;
      4'b0110: alu_res = $unsigned($signed(a) >>> shamt);
      4'b0111: alu_res = a >> shamt;
      4'b1000: alu_res = a | op2;
      4'b1001: alu_res = a & op2;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = start_iter ? BUSY : DONE;
      BUSY:    if (iter_last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     out_data <= '0;
    else if (accept && !start_iter) out_data <= alu_res;
    else if (iter_last)           out_data <= iter_res;
  end

`ifdef ALU_ITER_MULDIV_EN
  localparam int                CNT_W    = $clog2(XLEN);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(XLEN - 1);

  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   hi, lo, md;
  logic [XLEN-1:0]   hi_nxt, lo_nxt;
  logic [2:0]        op_q;
  logic              neg_q;
  logic              is_iter, signed_op, a_neg, b_neg, neg_start;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] prod_fix;

  assign is_iter    = op[3] & (op[2] | op[1]);
  assign start_iter = accept && is_iter;
  assign iter_last  = (state == BUSY) && (cnt == CNT_LAST);

  // Both units work on magnitudes; neg_start records whether the final result needs negating.
  always_comb begin
    signed_op = op[2] ? ~op[0] : op[0];
    a_neg     = signed_op & a[XLEN-1];
    b_neg     = signed_op & op2[XLEN-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -op2 : op2;
    if (!op[2])     neg_start = a_neg ^ b_neg;
    else if (op[1]) neg_start = a_neg;
    else            neg_start = (a_neg ^ b_neg) & (|op2);
  end

  // One shift-add (multiply) or restoring-subtract (divide) step per cycle; {hi,lo} holds the partials.
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, md} : {(XLEN+1){1'b0}});
    div_shift = {hi, lo[XLEN-1]};
    div_diff  = div_shift - {1'b0, md};
    if (op_q[2]) begin
      hi_nxt = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
      lo_nxt = {lo[XLEN-2:0], ~div_diff[XLEN]};
    end else begin
      hi_nxt = mul_sum[XLEN:1];
      lo_nxt = {mul_sum[0], lo[XLEN-1:1]};
    end
    prod_fix = neg_q ? -{hi_nxt, lo_nxt} : {hi_nxt, lo_nxt};
    if (!op_q[2])     iter_res = op_q[0] ? prod_fix[2*XLEN-1:XLEN] : lo_nxt;
    else if (op_q[1]) iter_res = neg_q ? -hi_nxt : hi_nxt;
    else              iter_res = neg_q ? -lo_nxt : lo_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      md    <= '0;
      op_q  <= '0;
      neg_q <= 1'b0;
    end else if (start_iter) begin
      cnt   <= '0;
      hi    <= '0;
      lo    <= a_mag;
      md    <= b_mag;
      op_q  <= op[2:0];
      neg_q <= neg_start;
    end else if (state == BUSY) begin
      cnt <= cnt + 1'b1;
      hi  <= hi_nxt;
      lo  <= lo_nxt;
    end
  end
`else
  assign start_iter = 1'b0;
  assign iter_last  = 1'b0;
  assign iter_res   = '0;
`endif

endmodule

// File: tb/tb_alu_iter.sv
// Directed testbench for alu_iter (XLEN=32); expectations follow ALU_ITER_MULDIV_EN when it is defined.
module tb_alu_iter;
  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;
`ifdef ALU_ITER_MULDIV_EN
  localparam bit MULDIV = 1'b1;
`else
  localparam bit MULDIV = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic               imm_en = 1'b0;
  logic [XLEN-1:0]    a = '0, b = '0, imm = '0;
  logic [3:0]         op = '0;
  logic [SHAMT_W-1:0] shamt = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [XLEN-1:0]    out_data;
  logic               busy;
  logic [1:0]         dbg_state;

  int tests_run = 0;
  int tests_failed = 0;
  logic [XLEN-1:0] exp_q[$];

  typedef struct {
    logic [3:0]         op;
    logic [XLEN-1:0]    a, b, imm;
    logic               ie;
    logic [SHAMT_W-1:0] sh;
    logic [XLEN-1:0]    exp;
  } vec_t;

  always #5 clk = ~clk;

  alu_iter #(.XLEN(XLEN), .SHAMT_W(SHAMT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .imm_en(imm_en), .a(a), .b(b), .imm(imm), .op(op), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Presents a request for one edge, then scrambles the inputs to catch late sampling.
  task automatic send_req(input logic [3:0] o, input logic [XLEN-1:0] va, input logic [XLEN-1:0] vb,
                          input logic [XLEN-1:0] vi, input logic ie, input logic [SHAMT_W-1:0] sh);
    @(negedge clk);
    op = o; a = va; b = vb; imm = vi; imm_en = ie; shamt = sh; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; imm = $urandom;
    op = 4'($urandom_range(0, 15)); shamt = SHAMT_W'($urandom_range(0, 31)); imm_en = 1'($urandom_range(0, 1));
  endtask

  // Called 1 time unit after acceptance; lat=1 means out_valid was already high in the first cycle.
  task automatic wait_result(input int limit, output int lat, output logic rdy_seen);
    lat = 1;
    rdy_seen = 1'b0;
    while (!out_valid && lat < limit) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_result;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests_run++;
    if (out_data !== '0) begin tests_failed++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    tests_run++;
    if (dbg_state !== 2'd0) begin tests_failed++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_alu;
    vec_t v[13];
    int lat;
    logic rdy_seen;
    logic [XLEN-1:0] exp;
    v[0]  = '{4'h0, 32'hFFFFFFFF, 32'h00000001, 32'h0,        1'b0, 5'd0,  32'h00000000};
    v[1]  = '{4'h1, 32'h00000005, 32'h00000007, 32'h0,        1'b0, 5'd0,  32'hFFFFFFFE};
    v[2]  = '{4'h2, 32'h00000001, 32'hFFFFFFFF, 32'h0,        1'b0, 5'd31, 32'h80000000};
    v[3]  = '{4'h3, 32'hFFFFFFFF, 32'h00000001, 32'h0,        1'b0, 5'd0,  32'h00000001};
    v[4]  = '{4'h3, 32'h00000001, 32'hFFFFFFFF, 32'h0,        1'b0, 5'd0,  32'h00000000};
    v[5]  = '{4'h4, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b1, 5'd0,  32'h00000001};
    v[6]  = '{4'h4, 32'hFFFFFFFF, 32'h00000001, 32'h0,        1'b0, 5'd0,  32'h00000000};
    v[7]  = '{4'h5, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,        1'b0, 5'd0,  32'hFF00FF00};
    v[8]  = '{4'h6, 32'h80000000, 32'h00000000, 32'h0,        1'b0, 5'd4,  32'hF8000000};
    v[9]  = '{4'h7, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1'b0, 5'd4,  32'h08000000};
    v[10] = '{4'h8, 32'h12340000, 32'h00005678, 32'h0,        1'b0, 5'd0,  32'h12345678};
    v[11] = '{4'h9, 32'hFFFF0000, 32'hFFFFFFFF, 32'h0F0F0F0F, 1'b1, 5'd0,  32'h0F0F0000};
    v[12] = '{4'h0, 32'h00000010, 32'hFFFFFFFF, 32'h00000020, 1'b1, 5'd0,  32'h00000030};
    for (int i = 0; i < 13; i++) begin
      exp_q.push_back(v[i].exp);
      send_req(v[i].op, v[i].a, v[i].b, v[i].imm, v[i].ie, v[i].sh);
      wait_result(60, lat, rdy_seen);
      tests_run++;
      if (lat !== 1) begin tests_failed++; $display("FAIL alu_latency[%0d]: got %0d want 1", i, lat); end
      exp = exp_q.pop_front();
      tests_run++;
      if (out_data !== exp) begin tests_failed++; $display("FAIL alu_data[%0d] op=%h: got %h want %h", i, v[i].op, out_data, exp); end
      release_result();
    end
  endtask

  task automatic test_muldiv;
    vec_t v[13];
    int lat;
    int exp_lat;
    logic rdy_seen;
    logic [XLEN-1:0] exp;
    v[0]  = '{4'hB, 32'h80000000, 32'h80000000, 32'h0, 1'b0, 5'd0, 32'h40000000};
    v[1]  = '{4'hA, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0, 5'd0, 32'h00000001};
    v[2]  = '{4'hB, 32'hFFFFFFFF, 32'h00000002, 32'h0, 1'b0, 5'd0, 32'hFFFFFFFF};
    v[3]  = '{4'hC, 32'h00000007, 32'h00000000, 32'h0, 1'b0, 5'd0, 32'hFFFFFFFF};
    v[4]  = '{4'hD, 32'h00000007, 32'h00000000, 32'h0, 1'b0, 5'd0, 32'hFFFFFFFF};
    v[5]  = '{4'hE, 32'h00000007, 32'h00000000, 32'h0, 1'b0, 5'd0, 32'h00000007};
    v[6]  = '{4'hE, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b0, 5'd0, 32'h00000000};
    v[7]  = '{4'hC, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b0, 5'd0, 32'h80000000};
    v[8]  = '{4'hC, 32'hFFFFFFF9, 32'h00000002, 32'h0, 1'b0, 5'd0, 32'hFFFFFFFD};
    v[9]  = '{4'hE, 32'hFFFFFFF9, 32'h00000002, 32'h0, 1'b0, 5'd0, 32'hFFFFFFFF};
    v[10] = '{4'hD, 32'h00000064, 32'h00000007, 32'h0, 1'b0, 5'd0, 32'h0000000E};
    v[11] = '{4'hF, 32'h00000064, 32'h00000007, 32'h0, 1'b0, 5'd0, 32'h00000002};
    v[12] = '{4'hA, 32'h00000003, 32'hFFFFFFFF, 32'h5, 1'b1, 5'd0, 32'h0000000F};
    exp_lat = MULDIV ? XLEN + 1 : 1;
    for (int i = 0; i < 13; i++) begin
      exp_q.push_back(MULDIV ? v[i].exp : '0);
      send_req(v[i].op, v[i].a, v[i].b, v[i].imm, v[i].ie, v[i].sh);
      wait_result(80, lat, rdy_seen);
      tests_run++;
      if (lat !== exp_lat) begin tests_failed++; $display("FAIL muldiv_latency[%0d]: got %0d want %0d", i, lat, exp_lat); end
      tests_run++;
      if (rdy_seen !== 1'b0) begin tests_failed++; $display("FAIL muldiv_in_ready[%0d]: got high while busy, want low", i); end
      exp = exp_q.pop_front();
      tests_run++;
      if (out_data !== exp) begin tests_failed++; $display("FAIL muldiv_data[%0d] op=%h: got %h want %h", i, v[i].op, out_data, exp); end
      release_result();
    end
  endtask

  task automatic test_backpressure;
    int lat;
    logic rdy_seen;
    send_req(4'h5, 32'hA5A5A5A5, 32'hFFFF0000, 32'h0, 1'b0, 5'd0);
    wait_result(60, lat, rdy_seen);
    tests_run++;
    if (lat !== 1) begin tests_failed++; $display("FAIL bp_latency: got %0d want 1", lat); end
    @(negedge clk);
    op = 4'h0; a = 32'h1; b = 32'h1; imm_en = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== 32'h5A5AA5A5 || in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d]: got valid=%b data=%h in_ready=%b want 1 5a5aa5a5 0", i, out_valid, out_data, in_ready);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_release: got valid=%b busy=%b in_ready=%b want 0 0 1", out_valid, busy, in_ready);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL bp_no_accept: got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid;
    int lat;
    logic rdy_seen;
    logic valid_seen;
    send_req(4'hD, 32'd1000, 32'd7, 32'h0, 1'b0, 5'd0);
    repeat (9) @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_pre_busy: got %b want 1", busy); end
    rst = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0) begin
      tests_failed++;
      $display("FAIL rst_mid_clear: got valid=%b busy=%b data=%h want 0 0 0", out_valid, busy, out_data);
    end
    @(negedge clk);
    rst = 1'b1;
    valid_seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) valid_seen = 1'b1;
    end
    tests_run++;
    if (valid_seen !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_no_pulse: got out_valid pulse, want none"); end
    send_req(4'h0, 32'd2, 32'd3, 32'h0, 1'b0, 5'd0);
    wait_result(60, lat, rdy_seen);
    tests_run++;
    if (lat !== 1 || out_data !== 32'd5) begin
      tests_failed++;
      $display("FAIL rst_mid_add: got lat=%0d data=%h want 1 00000005", lat, out_data);
    end
    release_result();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_muldiv();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 Parameter XLEN, default 32, SHALL set operand and result width (legal values 8..64, power of two).
REQ-002 Parameter SHAMT_W, default $clog2(XLEN), SHALL set the shift-amount width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 in_valid  input  1  SHALL mark a request present.
REQ-006 in_ready  output  1  SHALL mark the block able to accept a request.
REQ-007 imm_en  input  1  SHALL select imm (1) or b (0) as operand 2.
REQ-008 a, b, imm  input  XLEN each  SHALL be operand 1, register operand 2 and immediate operand 2.
REQ-009 op  input  4  SHALL be the operation code.
REQ-010 shamt  input  SHAMT_W  SHALL be the shift amount.
REQ-011 out_valid  output  1  SHALL mark result present.
REQ-012 out_ready  input  1  SHALL mark consumer accepting the result.
REQ-013 out_data  output  XLEN  SHALL be the result.
REQ-014 busy  output  1  SHALL be high in any state other than IDLE.

Function
REQ-015 op encoding SHALL be: 0000 add, 0001 sub, 0010 sll, 0011 slt, 0100 sltu, 0101 xor, 0110 sra, 0111 srl, 1000 or, 1001 and, 1010 mul (low XLEN), 1011 mulh (signed x signed, high XLEN), 1100 div, 1101 divu, 1110 rem, 1111 remu.
REQ-016 A request SHALL be accepted on a rising edge with in_valid && in_ready; a, operand 2, op and shamt SHALL be captured at acceptance and later input changes ignored.
REQ-017 FSM states SHALL be IDLE, BUSY, DONE; in_ready SHALL be high only in IDLE.
REQ-018 Ops 0000-1001 SHALL go IDLE->DONE with out_valid high the cycle after acceptance (latency 1).
REQ-019 Ops 1010-1111 SHALL go IDLE->BUSY, iterate one bit per cycle with an XLEN-cycle counter, then BUSY->DONE; out_valid high exactly XLEN+1 cycles after acceptance.
REQ-020 slt/sltu SHALL return zero-extended 1 or 0; shifts SHALL use shamt only, not operand 2.
REQ-021 Add/sub/mul low SHALL wrap modulo 2^XLEN with no overflow flag.
REQ-022 Divide by zero: div/divu quotient SHALL be all ones; rem/remu SHALL return operand 1.
REQ-023 Signed overflow (operand 1 = most negative, operand 2 = -1): div SHALL return operand 1, rem SHALL return 0.
REQ-024 In DONE, out_data and out_valid SHALL hold stable until out_ready is high; DONE->IDLE on out_ready, with no same-cycle new acceptance.
REQ-025 out_ready while out_valid is low SHALL be ignored; in_valid while in_ready is low SHALL be ignored.

Reset
REQ-026 Reset assertion SHALL asynchronously force state IDLE, out_valid 0, out_data 0, busy 0, counter 0, in_ready 1 after release.
REQ-027 Reset during BUSY or DONE SHALL abort the operation and discard its result; no out_valid pulse follows.

Configuration
REQ-028 With macro ALU_ITER_MULDIV_EN defined, ops 1010-1111 SHALL behave per REQ-019..REQ-023.
REQ-029 Without ALU_ITER_MULDIV_EN, the iterative datapath and counter SHALL be omitted, ops 1010-1111 SHALL complete with latency 1 and out_data 0, and busy SHALL only be high in DONE.

Verification
REQ-030 XLEN=32: add a=0xFFFFFFFF, b=1, imm_en=0 -> out_valid next cycle, out_data 0x00000000.
REQ-031 sra a=0x80000000, shamt=4 -> 0xF8000000; sltu a=1, imm=0xFFFFFFFF, imm_en=1 -> 1.
REQ-032 mulh a=0x80000000, b=0x80000000 -> 0x40000000 exactly 33 cycles after acceptance; in_ready low throughout.
REQ-033 div a=7, b=0 -> 0xFFFFFFFF; rem a=0x80000000, b=0xFFFFFFFF -> 0; div same operands -> 0x80000000.
REQ-034 out_ready held low 5 cycles after xor result -> out_data stable, in_valid ignored; out_ready high -> IDLE next cycle.
REQ-035 rst low at cycle 10 of a divu -> out_valid 0, busy 0 immediately; after release, new add accepted and correct.
